// File: rtl/cam_pkg.sv
// Shared types and constants for the camera frame-capture writer.
package cam_pkg;

    // Capture FSM states; also exported on the debug state port.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_VSYNC = 2'd1,
        CAPTURE    = 2'd2,
        DONE       = 2'd3
    } cam_state_t;

    // RGB565 byte-lane layout: even address = {R[4:0], G[5:3]}, odd = {G[2:0], B[4:0]}.
    localparam int   RED_W            = 5;
    localparam int   GREEN_W          = 6;
    localparam int   BLUE_W           = 5;
    localparam int   GREEN_HI_W       = 3;
    localparam int   GREEN_LO_W       = 3;
    localparam logic HI_BYTE_ADDR_LSB = 1'b0;
    localparam logic LO_BYTE_ADDR_LSB = 1'b1;

    // Default frame size: 80 x 120 pixels, 2 bytes per pixel.
    localparam int FRAME_BYTES = 19200;

endpackage

// File: rtl/cam_input_sync.sv
// Synchronizes the camera bus into the system clock domain and detects
// pclk rising edges and vsync edges. pclk, vsync, href and data all pass
// through the same number of stages so data/href line up with pclk_rise.
// SYNC_STAGES must be at least 2.
module cam_input_sync #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pclk,
    input  logic              vsync,
    input  logic              href,
    input  logic [DATA_W-1:0] data,
    output logic              pclk_rise,
    output logic              vsync_rise,
    output logic              vsync_fall,
    output logic              href_s,
    output logic [DATA_W-1:0] data_s
);

    logic [SYNC_STAGES-1:0] pclk_sr;
    logic [SYNC_STAGES-1:0] vsync_sr;
    logic [SYNC_STAGES-1:0] href_sr;
    logic [DATA_W-1:0]      data_sr [SYNC_STAGES];
    logic                   pclk_prev;
    logic                   vsync_prev;

    // Synchronizer chains plus one history flop for the edge detectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_sr    <= '0;
            vsync_sr   <= '0;
            href_sr    <= '0;
            pclk_prev  <= 1'b0;
            vsync_prev <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sr[i] <= '0;
            end
        end else begin
            pclk_sr    <= {pclk_sr[SYNC_STAGES-2:0], pclk};
            vsync_sr   <= {vsync_sr[SYNC_STAGES-2:0], vsync};
            href_sr    <= {href_sr[SYNC_STAGES-2:0], href};
            pclk_prev  <= pclk_sr[SYNC_STAGES-1];
            vsync_prev <= vsync_sr[SYNC_STAGES-1];
            data_sr[0] <= data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sr[i] <= data_sr[i-1];
            end
        end
    end

    // Edge decode on the last synchronized stage.
    always_comb begin
        pclk_rise  = pclk_sr[SYNC_STAGES-1] & ~pclk_prev;
        vsync_rise = vsync_sr[SYNC_STAGES-1] & ~vsync_prev;
        vsync_fall = ~vsync_sr[SYNC_STAGES-1] & vsync_prev;
        href_s     = href_sr[SYNC_STAGES-1];
        data_s     = data_sr[SYNC_STAGES-1];
    end

endmodule

// File: rtl/camera_frame_capture.sv
// Writer side of the frame-buffer RAM: captures one camera frame per arm
// into consecutive byte addresses and pulses o_done when it is complete.
// RAM write port: o_ram_addr/o_ram_data are meaningful only in cycles with
// o_ram_we=1; the RAM accepts every write, so there is no back-pressure.
module camera_frame_capture
    import cam_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [ADDR_W-1:0] i_bytes_per_frame,
    input  logic              i_pclk,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [DATA_W-1:0] i_data,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_data,
    output logic              o_ram_we,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_short_frame,
    output logic [ADDR_W-1:0] o_byte_count,
    output cam_state_t        o_state
);

    cam_state_t        state_q, state_d;
    logic [ADDR_W-1:0] limit_q;
    logic [ADDR_W-1:0] addr_q;
    logic              pclk_rise, vsync_rise, vsync_fall, href_s;
    logic [DATA_W-1:0] data_s;
    logic              write_fire, last_byte, at_limit;
    logic              latch_limit, start_frame, set_short;

    cam_input_sync #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (i_clk),
        .rst        (i_rst),
        .pclk       (i_pclk),
        .vsync      (i_vsync),
        .href       (i_href),
        .data       (i_data),
        .pclk_rise  (pclk_rise),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .href_s     (href_s),
        .data_s     (data_s)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a final write coincident with vsync rise counts as a full frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (i_enable) state_d = WAIT_VSYNC;
            WAIT_VSYNC: begin
                if (!i_enable)       state_d = IDLE;
                else if (vsync_fall) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!i_enable)                           state_d = IDLE;
                else if (at_limit)                       state_d = DONE;
                else if (write_fire && last_byte)        state_d = DONE;
                else if (vsync_rise)                     state_d = DONE;
            end
            DONE:       state_d = i_enable ? WAIT_VSYNC : IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Output and datapath-control decode.
    always_comb begin
        at_limit     = (addr_q == limit_q);
        last_byte    = ((addr_q + ADDR_W'(1)) == limit_q);
        write_fire   = (state_q == CAPTURE) && pclk_rise && href_s && (addr_q < limit_q);
        latch_limit  = i_enable && ((state_q == IDLE) || (state_q == DONE));
        start_frame  = (state_q == WAIT_VSYNC) && i_enable && vsync_fall;
        set_short    = (state_q == CAPTURE) && i_enable && !at_limit && vsync_rise
                       && !(write_fire && last_byte);
        o_busy       = (state_q == WAIT_VSYNC) || (state_q == CAPTURE);
        o_done       = (state_q == DONE);
        o_byte_count = addr_q;
        o_state      = state_q;
    end

    // Address/count, latched limit, RAM write port and short-frame flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            limit_q       <= '0;
            addr_q        <= '0;
            o_ram_we      <= 1'b0;
            o_ram_addr    <= '0;
            o_ram_data    <= '0;
            o_short_frame <= 1'b0;
        end else begin
            o_ram_we <= write_fire;
            if (latch_limit) limit_q <= i_bytes_per_frame;
            if (start_frame) begin
                addr_q        <= '0;
                o_short_frame <= 1'b0;
            end else if (write_fire) begin
                addr_q     <= addr_q + ADDR_W'(1);
                o_ram_addr <= addr_q;
                o_ram_data <= data_s;
            end
            if (set_short) o_short_frame <= 1'b1;
        end
    end

endmodule
